// File: rtl/nic_pkg.sv
// Shared constants and types for the network interface controller.
// Register-window addresses and packet layout live here so that the top level and the bench agree on them.
package nic_pkg;

   localparam int DATA_W = 64;
   localparam int VC_BIT = 63;

   localparam logic [1:0] ADDR_RX_BUF  = 2'b00;
   localparam logic [1:0] ADDR_RX_STAT = 2'b01;
   localparam logic [1:0] ADDR_TX_BUF  = 2'b10;
   localparam logic [1:0] ADDR_TX_STAT = 2'b11;

   typedef logic [DATA_W-1:0] pkt_t;

endpackage

// File: rtl/nic_channel_buf.sv
// Single-entry packet buffer with a full flag.
// A load is taken only while the buffer is empty; a clear empties it but keeps the stale data.
module nic_channel_buf
   import nic_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  pkt_t load_data,
   input  logic clear,
   output logic full,
   output pkt_t data
);

   // Load and clear cannot both be effective in one cycle: load needs empty, clear needs full.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         full <= 1'b0;
         data <= '0;
      end else if (load && !full) begin
         full <= 1'b1;
         data <= load_data;
      end else if (clear) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/network_interface_ctrl.sv
// Network interface controller: processor register window over one tx and one rx packet buffer,
// with a send/ready handshake to the router PE port that injects only on a matching polarity.
module network_interface_ctrl
   import nic_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        addr,
   input  logic [DATA_W-1:0] d_in,
   output logic [DATA_W-1:0] d_out,
   input  logic              nic_en,
   input  logic              nic_wr_en,
   output logic              net_so,
   input  logic              net_ro,
   output logic [DATA_W-1:0] net_do,
   input  logic              net_polarity,
   input  logic              net_si,
   output logic              net_ri,
   input  logic [DATA_W-1:0] net_di
);

   logic tx_full;
   logic rx_full;
   pkt_t tx_buf;
   pkt_t rx_buf;
   logic cpu_rd;
   logic tx_load;
   logic rx_load;
   logic rx_clear;

   assign cpu_rd   = nic_en && !nic_wr_en;
   assign tx_load  = nic_en && nic_wr_en && (addr == ADDR_TX_BUF);
   assign rx_load  = net_si && net_ri;
   assign rx_clear = cpu_rd && (addr == ADDR_RX_BUF);

   // A packet leaves only in a cycle whose router polarity equals its virtual-channel bit.
   assign net_so = tx_full && net_ro && (net_polarity == tx_buf[VC_BIT]);
   assign net_do = tx_buf;
   assign net_ri = !rx_full;

   nic_channel_buf u_tx_buf (
      .clk       (clk),
      .reset     (reset),
      .load      (tx_load),
      .load_data (d_in),
      .clear     (net_so),
      .full      (tx_full),
      .data      (tx_buf)
   );

   nic_channel_buf u_rx_buf (
      .clk       (clk),
      .reset     (reset),
      .load      (rx_load),
      .load_data (net_di),
      .clear     (rx_clear),
      .full      (rx_full),
      .data      (rx_buf)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         d_out <= '0;
      end else if (cpu_rd) begin
         case (addr)
            ADDR_RX_BUF:  d_out <= rx_buf;
            ADDR_RX_STAT: d_out <= {{(DATA_W-1){1'b0}}, rx_full};
            ADDR_TX_STAT: d_out <= {{(DATA_W-1){1'b0}}, tx_full};
            default:      d_out <= '0;
         endcase
      end
   end

endmodule
